// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the decode-stage immediate generator:
// format codes and the RV32I/RV64I base opcodes it recognises.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bus of the immediate generator: instruction/tag in, decoded
// immediate/format out, plus the branch-redirect flush.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    import imm_gen_pipe_pkg::*;

    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      inst_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  imm_o;
    fmt_e             fmt_o;
    logic             illegal_o;
    logic [31:0]      inst_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output flush_i, in_valid_i, inst_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, inst_o, tag_o
    );

    modport slave (
        input  flush_i, in_valid_i, inst_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, inst_o, tag_o
    );

endinterface

// File: rtl/imm_gen_pipe_imm_fmt_decode.sv
// Combinational RV32I/RV64I immediate decoder: inst -> {imm, fmt, illegal}.
// Illegal encodings always report imm = 0 and FMT_NONE.
module imm_fmt_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    localparam logic IS64 = (XLEN == 64) ? 1'b1 : 1'b0;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       is_shift_s;
    logic       shift_ok_s;

    assign opcode_s   = inst[6:0];
    assign funct3_s   = inst[14:12];
    assign is_shift_s = (funct3_s == F3_SLL) || (funct3_s == F3_SR);

    // Upper funct bits of a shift: zero, or the arithmetic-right pattern on SRAI only
    always_comb begin
        shift_ok_s = 1'b0;
        if (IS64) begin
            shift_ok_s = (inst[31:26] == 6'b000000) ||
                         ((inst[31:26] == 6'b010000) && (funct3_s == F3_SR));
        end else begin
            shift_ok_s = (inst[31:25] == 7'b0000000) ||
                         ((inst[31:25] == 7'b0100000) && (funct3_s == F3_SR));
        end
    end

    // Format selection and immediate assembly by opcode
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode_s)
                OPCODE_OP_IMM: begin
                    if (!is_shift_s) begin
                        imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
                        fmt = FMT_I;
                    end else if (shift_ok_s) begin
                        imm = {{(XLEN-6){1'b0}}, inst[25] & IS64, inst[24:20]};
                        fmt = FMT_I;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPCODE_LOAD, OPCODE_JALR, OPCODE_SYSTEM: begin
                    imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
                    fmt = FMT_I;
                end
                OPCODE_STORE: begin
                    imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
                    fmt = FMT_S;
                end
                OPCODE_BRANCH: begin
                    imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                    fmt = FMT_B;
                end
                OPCODE_LUI, OPCODE_AUIPC: begin
                    imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'h000};
                    fmt = FMT_U;
                end
                OPCODE_JAL: begin
                    imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                    fmt = FMT_J;
                end
                OPCODE_OP: begin
                    fmt = FMT_R;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a one-entry skid buffer, so execute can
// stall without losing or reordering instructions; all outputs come from flops.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0]  dec_imm_s;
    fmt_e             dec_fmt_s;
    logic             dec_ill_s;

    logic             out_valid_r, skid_valid_r, in_ready_r;
    logic [XLEN-1:0]  out_imm_r, skid_imm_r;
    fmt_e             out_fmt_r, skid_fmt_r;
    logic             out_ill_r, skid_ill_r;
    logic [31:0]      out_inst_r, skid_inst_r;
    logic [TAG_W-1:0] out_tag_r, skid_tag_r;

    logic accept_s, consume_s;
    logic out_load_in_s, out_load_skid_s, skid_load_s;
    logic out_valid_nxt_s, skid_valid_nxt_s;

    imm_fmt_decode #(.XLEN(XLEN)) u_decode (
        .inst    (bus.inst_i),
        .imm     (dec_imm_s),
        .fmt     (dec_fmt_s),
        .illegal (dec_ill_s)
    );

    assign accept_s  = bus.in_valid_i & in_ready_r;
    assign consume_s = out_valid_r & bus.out_ready_i;

    // Slot steering: a free OUT slot drains SKID first to keep FIFO order
    always_comb begin
        out_load_in_s    = 1'b0;
        out_load_skid_s  = 1'b0;
        skid_load_s      = 1'b0;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (!out_valid_r || consume_s) begin
            if (skid_valid_r) begin
                out_load_skid_s  = 1'b1;
                out_valid_nxt_s  = 1'b1;
                skid_load_s      = accept_s;
                skid_valid_nxt_s = accept_s;
            end else begin
                out_load_in_s    = accept_s;
                out_valid_nxt_s  = accept_s;
            end
        end else begin
            skid_load_s      = accept_s;
            skid_valid_nxt_s = skid_valid_r | accept_s;
        end
    end

    // Slot state and payload registers; flush only drops the valids
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            out_imm_r    <= '0;
            out_fmt_r    <= FMT_NONE;
            out_ill_r    <= 1'b0;
            out_inst_r   <= 32'h0000_0000;
            out_tag_r    <= '0;
            skid_imm_r   <= '0;
            skid_fmt_r   <= FMT_NONE;
            skid_ill_r   <= 1'b0;
            skid_inst_r  <= 32'h0000_0000;
            skid_tag_r   <= '0;
        end else if (bus.flush_i) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= ~skid_valid_nxt_s;
            if (out_load_skid_s) begin
                out_imm_r  <= skid_imm_r;
                out_fmt_r  <= skid_fmt_r;
                out_ill_r  <= skid_ill_r;
                out_inst_r <= skid_inst_r;
                out_tag_r  <= skid_tag_r;
            end else if (out_load_in_s) begin
                out_imm_r  <= dec_imm_s;
                out_fmt_r  <= dec_fmt_s;
                out_ill_r  <= dec_ill_s;
                out_inst_r <= bus.inst_i;
                out_tag_r  <= bus.tag_i;
            end
            if (skid_load_s) begin
                skid_imm_r  <= dec_imm_s;
                skid_fmt_r  <= dec_fmt_s;
                skid_ill_r  <= dec_ill_s;
                skid_inst_r <= bus.inst_i;
                skid_tag_r  <= bus.tag_i;
            end
        end
    end

    assign bus.in_ready_o  = in_ready_r;
    assign bus.out_valid_o = out_valid_r;
    assign bus.imm_o       = out_imm_r;
    assign bus.fmt_o       = out_fmt_r;
    assign bus.illegal_o   = out_ill_r;
    assign bus.inst_o      = out_inst_r;
    assign bus.tag_o       = out_tag_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 instance under directed and random
// handshake traffic, plus an XLEN=64 instance for wide sign/shamt decoding.
module tb_imm_gen_pipe;

    localparam int TAG_W = 32;
    localparam int NV    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (.clk_i(clk), .rst_i(rst), .bus(bus64));

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] tag;
        int          idx;
    } exp_t;

    vec_t vecs [NV];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // One XLEN=32 cycle: drive at negedge, score the delivery, record the accept
    task automatic cyc(input logic v, input int idx, input logic [31:0] tag, input logic rdy,
                       input logic fl, output logic acc, output logic ov, output logic ir);
        exp_t e;
        int   n;
        @(negedge clk);
        bus32.in_valid_i  = v;
        bus32.inst_i      = vecs[idx].inst;
        bus32.tag_i       = tag;
        bus32.out_ready_i = rdy;
        bus32.flush_i     = fl;
        ov  = bus32.out_valid_o;
        ir  = bus32.in_ready_o;
        acc = v & ir;
        if (ov && rdy) begin
            n = sb.size();
            check_val("out_expected", 64'(n > 0), 64'd1);
            if (n > 0) begin
                e = sb.pop_front();
                check_val($sformatf("tag_%0d", e.tag), 64'(bus32.tag_o), 64'(e.tag));
                check_val($sformatf("inst_%0d", e.tag), 64'(bus32.inst_o), 64'(vecs[e.idx].inst));
                check_val($sformatf("imm_%0d", e.tag), 64'(bus32.imm_o), 64'(vecs[e.idx].imm));
                check_val($sformatf("fmt_%0d", e.tag), 64'(bus32.fmt_o), 64'(vecs[e.idx].fmt));
                check_val($sformatf("ill_%0d", e.tag), 64'(bus32.illegal_o), 64'(vecs[e.idx].ill));
            end
        end
        if (fl) begin
            sb.delete();
        end else if (acc) begin
            e.tag = tag;
            e.idx = idx;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic check_reset32(input string pfx);
        check_val({pfx, "_out_valid"}, 64'(bus32.out_valid_o), 64'd0);
        check_val({pfx, "_in_ready"},  64'(bus32.in_ready_o),  64'd1);
        check_val({pfx, "_imm"},       64'(bus32.imm_o),       64'd0);
        check_val({pfx, "_fmt"},       64'(bus32.fmt_o),       64'd0);
        check_val({pfx, "_illegal"},   64'(bus32.illegal_o),   64'd0);
        check_val({pfx, "_inst"},      64'(bus32.inst_o),      64'd0);
        check_val({pfx, "_tag"},       64'(bus32.tag_o),       64'd0);
    endtask

    task automatic run64(input string name, input logic [31:0] inst, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic ill, input logic [31:0] tag);
        @(negedge clk);
        bus64.in_valid_i = 1'b1;
        bus64.inst_i     = inst;
        bus64.tag_i      = tag;
        @(negedge clk);
        bus64.in_valid_i = 1'b0;
        check_val({name, "_valid"}, 64'(bus64.out_valid_o), 64'd1);
        check_val({name, "_imm"},   bus64.imm_o,            imm);
        check_val({name, "_fmt"},   64'(bus64.fmt_o),       64'(fmt));
        check_val({name, "_ill"},   64'(bus64.illegal_o),   64'(ill));
        check_val({name, "_tag"},   64'(bus64.tag_o),       64'(tag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc, ov, ir;
        logic [31:0] t;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd2, 1'b0};
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd3, 1'b0};
        vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd4, 1'b0};
        vecs[3]  = '{32'h123450B7, 32'h12345000, 3'd5, 1'b0};
        vecs[4]  = '{32'h0010006F, 32'h00000800, 3'd6, 1'b0};
        vecs[5]  = '{32'h4070D093, 32'h00000007, 3'd2, 1'b0};
        vecs[6]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1};
        vecs[7]  = '{32'h02009093, 32'h00000000, 3'd0, 1'b1};
        vecs[8]  = '{32'h003100B3, 32'h00000000, 3'd1, 1'b0};
        vecs[9]  = '{32'h00412083, 32'h00000004, 3'd2, 1'b0};
        vecs[10] = '{32'hFFFFF097, 32'hFFFFF000, 3'd5, 1'b0};
        vecs[11] = '{32'h40009093, 32'h00000000, 3'd0, 1'b1};
        vecs[12] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1};
        vecs[13] = '{32'h800000EF, 32'hFFF00000, 3'd6, 1'b0};
        vecs[14] = '{32'h80000063, 32'hFFFFF000, 3'd4, 1'b0};
        vecs[15] = '{32'h0000000F, 32'h00000000, 3'd0, 1'b1};

        rst = 1'b1;
        bus32.flush_i = 1'b0; bus32.in_valid_i = 1'b0; bus32.inst_i = 32'h0;
        bus32.tag_i = 32'h0;  bus32.out_ready_i = 1'b0;
        bus64.flush_i = 1'b0; bus64.in_valid_i = 1'b0; bus64.inst_i = 32'h0;
        bus64.tag_i = 32'h0;  bus64.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset32("reset");
        check_val("reset64_valid", 64'(bus64.out_valid_o), 64'd0);
        check_val("reset64_imm",   bus64.imm_o,            64'd0);

        // Single issues: each result must be valid exactly one cycle later
        for (int i = 0; i < NV; i++) begin
            cyc(1'b1, i, 32'(100 + i), 1'b1, 1'b0, acc, ov, ir);
            cyc(1'b0, 0, 32'h0, 1'b1, 1'b0, acc, ov, ir);
            check_val($sformatf("latency_%0d", i), 64'(ov), 64'd1);
        end

        // Back-pressure: tags 1..4 back-to-back, downstream stalled for 4 cycles
        t = 32'd1;
        for (int c = 1; c <= 20; c++) begin
            cyc(t <= 32'd4, int'(t % NV), t, c > 4, 1'b0, acc, ov, ir);
            if (c <= 4) check_val($sformatf("bp_in_ready_c%0d", c), 64'(ir), (c < 3) ? 64'd1 : 64'd0);
            if (c == 3) check_val("bp_out_tag_c3", 64'(bus32.tag_o), 64'd1);
            if (acc) t++;
        end
        check_val("bp_all_accepted", 64'(t), 64'd5);
        check_val("bp_drained", 64'(sb.size()), 64'd0);

        // Flush with both slots full and an input offered
        cyc(1'b1, 0, 32'd201, 1'b0, 1'b0, acc, ov, ir);
        cyc(1'b1, 1, 32'd202, 1'b0, 1'b0, acc, ov, ir);
        cyc(1'b1, 2, 32'd203, 1'b0, 1'b1, acc, ov, ir);
        cyc(1'b0, 0, 32'h0, 1'b1, 1'b0, acc, ov, ir);
        check_val("flush1_out_valid", 64'(ov), 64'd0);
        check_val("flush1_in_ready",  64'(ir), 64'd1);
        // Flush coinciding with a consume (delivered) and an accept (dropped)
        cyc(1'b1, 3, 32'd211, 1'b0, 1'b0, acc, ov, ir);
        cyc(1'b1, 4, 32'd212, 1'b1, 1'b1, acc, ov, ir);
        check_val("flush2_accept_seen", 64'(acc), 64'd1);
        cyc(1'b0, 0, 32'h0, 1'b1, 1'b0, acc, ov, ir);
        check_val("flush2_out_valid", 64'(ov), 64'd0);
        check_val("flush2_in_ready",  64'(ir), 64'd1);
        cyc(1'b1, 5, 32'd220, 1'b1, 1'b0, acc, ov, ir);
        cyc(1'b0, 0, 32'h0, 1'b1, 1'b0, acc, ov, ir);
        check_val("post_flush_valid", 64'(ov), 64'd1);

        // Reset while both slots are full
        cyc(1'b1, 0, 32'd301, 1'b0, 1'b0, acc, ov, ir);
        cyc(1'b1, 3, 32'd302, 1'b0, 1'b0, acc, ov, ir);
        @(negedge clk);
        rst = 1'b1;
        bus32.in_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_reset32("midrst");
        cyc(1'b1, 4, 32'd303, 1'b0, 1'b0, acc, ov, ir);
        check_val("midrst_accept", 64'(acc), 64'd1);
        cyc(1'b0, 0, 32'h0, 1'b1, 1'b0, acc, ov, ir);
        check_val("midrst_latency", 64'(ov), 64'd1);

        // Random handshake traffic with occasional flushes
        t = 32'd1000;
        for (int c = 0; c < 400; c++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)), t,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0), acc, ov, ir);
            if (acc) t++;
        end
        for (int c = 0; c < 20; c++) begin
            if (sb.size() != 0) cyc(1'b0, 0, 32'h0, 1'b1, 1'b0, acc, ov, ir);
        end
        check_val("random_drain", 64'(sb.size()), 64'd0);

        // XLEN=64 decoding
        run64("x64_addi",   32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd2, 1'b0, 32'd1);
        run64("x64_lui",    32'h800000B7, 64'hFFFFFFFF80000000, 3'd5, 1'b0, 32'd2);
        run64("x64_slli40", 32'h02809093, 64'd40,               3'd2, 1'b0, 32'd3);
        run64("x64_slli32", 32'h02009093, 64'd32,               3'd2, 1'b0, 32'd4);
        run64("x64_srai",   32'h4070D093, 64'd7,                3'd2, 1'b0, 32'd5);
        run64("x64_slli30", 32'h42009093, 64'd0,                3'd0, 1'b1, 32'd6);
        run64("x64_sw",     32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator with a valid/ready handshake. It sits at the head of the decode stage and supersedes the combinational `Imm_Gen`. It covers all RV32I/RV64I immediate formats (I, S, B, U, J, shift-amount), reports the decoded format and illegal encodings, and carries a side-band tag (normally the PC). A one-entry skid buffer lets it accept back-pressure from execute without losing or reordering instructions.

## Interface

Parameters:
- `XLEN`, 32: datapath width; only 32 and 64 are legal; controls sign extension and shamt width.
- `TAG_W`, 32: width of the side-band tag carried with each instruction.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  discard all held instructions (branch redirect).
- `in_valid_i`  in  1  upstream offers `inst_i`/`tag_i`.
- `in_ready_o`  out  1  block can accept this cycle.
- `inst_i`  in  32  instruction word.
- `tag_i`  in  TAG_W  side-band tag.
- `out_valid_o`  out  1  output holds a decoded instruction.
- `out_ready_i`  in  1  downstream consumes the output this cycle.
- `imm_o`  out  XLEN  decoded immediate.
- `fmt_o`  out  3  format code, `FMT_*`.
- `illegal_o`  out  1  encoding not recognised.
- `inst_o`  out  32  registered copy of the instruction.
- `tag_o`  out  TAG_W  registered copy of the tag.

## Operation

- Decode by `opcode = inst[6:0]`.
  - `OP_IMM`, `LOAD`, `JALR`, `SYSTEM`: I format; `sext(inst[31:20])`.
  - `STORE`: S format; `sext({inst[31:25], inst[11:7]})`.
  - `BRANCH`: B format; `sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})`.
  - `LUI`, `AUIPC`: U format; `sext({inst[31:12], 12'b0})`.
  - `JAL`: J format; `sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})`.
  - `OP`: R format; `imm = 0`.
- Shifts: `OP_IMM` with funct3 001 or 101.
  - Immediate is the shamt zero-extended: `inst[24:20]` when `XLEN=32`, `inst[25:20]` when `XLEN=64`.
  - `fmt = FMT_I`.
  - Upper funct bits must be all-zero or 0100000 (`XLEN=32`, bits [31:25]), or all-zero or 010000 (`XLEN=64`, bits [31:26]). Bit 30 may be set only for funct3 101. Anything else sets `illegal_o`.
- Illegal encodings: `inst[1:0] != 2'b11` or an unlisted opcode.
  - Outputs `imm = 0`, `fmt = FMT_NONE`, `illegal = 1`.
  - The instruction still flows through; it is not dropped.
- `sext` replicates `inst[31]` up to `XLEN`.
- Two storage slots: output register (OUT) and skid register (SKID).
  - States are OUT-empty, OUT-full/SKID-empty, and both full.
  - Decode is performed before each slot, so SKID holds decoded values.
  - Accept = `in_valid_i & in_ready_o`.
  - Consume = `out_valid_o & out_ready_i`.
- `in_ready_o` is the registered value `!SKID_full`; it is not combinationally dependent on `out_ready_i`.
- Per cycle, without flush:
  - OUT empty or consumed: OUT loads from SKID if SKID is full (SKID empties and accepts go to SKID); otherwise OUT loads from the accepted input.
  - OUT full and not consumed: an accepted input goes to SKID.
- Order is strictly FIFO; no instruction is duplicated or lost.
- `flush_i` has priority over everything.
  - Next cycle: OUT and SKID are empty and `in_ready_o = 1`.
  - An input accepted in the flush cycle is discarded.
  - A consume in the flush cycle still counts as delivered.
- Reset (mid-operation included) gives:
  - `out_valid_o = 0`, `in_ready_o = 1`, `imm_o = 0`, `fmt_o = FMT_NONE`, `illegal_o = 0`, `inst_o = 0`, `tag_o = 0`.
  - SKID is emptied.

## Timing

- Latency is 1 cycle: an input accepted at edge N is on the outputs with `out_valid_o = 1` after edge N.
- Throughput is 1 per cycle with `out_ready_i` held high.
- Downstream stall of k cycles:
  - At most one extra instruction is accepted.
  - `in_ready_o` falls the cycle after SKID fills.
  - It rises the cycle after SKID drains.
- Outputs are stable while `out_valid_o & !out_ready_i`.
- No combinational path from any input to any output.

## Structure

- Add to `Const.v`:
  - `FMT_NONE` = 0, `FMT_R` = 1, `FMT_I` = 2, `FMT_S` = 3, `FMT_B` = 4, `FMT_U` = 5, `FMT_J` = 6.
  - Missing opcode defines: `OPCODE_JAL`, `OPCODE_JALR`, `OPCODE_LUI`, `OPCODE_AUIPC`, `OPCODE_OP`, `OPCODE_SYSTEM`.
- One sub-module: `imm_fmt_decode` (parameter `XLEN`), purely combinational `inst -> {imm, fmt, illegal}`.
  - Instantiated once, on the input path; both slots load its result.

## Test plan

- `XLEN=32`, single issues → `imm_o` and `fmt_o` one cycle later:
  - `addi x1,x0,-1` (`0xFFF00093`) → `0xFFFFFFFF`, `FMT_I`.
  - `sw x1,-4(x2)` (`0xFE112E23`) → `0xFFFFFFFC`, `FMT_S`.
  - `beq x0,x0,-8` (`0xFE000CE3`) → `0xFFFFFFF8`, `FMT_B`.
  - `lui 0x12345` (`0x123450B7`) → `0x12345000`, `FMT_U`.
  - `jal x0,+2048` (`0x0010006F`) → `0x00000800`, `FMT_J`.
- Shift and illegal encodings:
  - `srai x1,x1,7` (`0x4070D093`) → `imm 0x7`, `FMT_I`, `illegal 0`.
  - `0x00000000` → `illegal 1`, `FMT_NONE`, `imm 0`.
  - `slli` with `inst[31:25] = 0x01` (`XLEN=32`) → `illegal 1`.
- `XLEN=64`:
  - `addi -1` → `0xFFFFFFFFFFFFFFFF`.
  - `lui 0x80000` (`0x800000B7`) → `0xFFFFFFFF80000000`.
  - `slli x1,x1,40` (`0x02809093`) → `imm 40`, legal.
- Back-pressure:
  - Stimulus: tags 1..4 offered back-to-back with `out_ready_i = 0` for cycles 1-4, then 1.
  - Response: tag 1 in OUT, tag 2 in SKID, `in_ready_o = 0` from cycle 3.
  - Response: delivered tag order is 1, 2, 3, 4 with no gaps or duplicates.
- Flush:
  - `flush_i` in the same cycle as an accept while both slots are full → next cycle `out_valid_o = 0`, `in_ready_o = 1`.
  - The flushed tags never appear on the output.
- Reset mid-stall:
  - Stimulus: `rst_i` while both slots are full.
  - Response: next cycle all outputs are at reset values.
  - Response: the first post-reset input appears after exactly 1 cycle.
